// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I core types for the writeback stage
// Contents: XLEN, load funct3 encodings, writeback FSM states.
package rv32_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_e;

   typedef enum logic [1:0] {
      IDLE,
      MEM_WAIT,
      WRITE,
      FAULT
   } wb_state_e;

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - combinational load data alignment and sign/zero extension
// Ports:
//   funct3  [2:0]  load width/sign encoding
//   offset  [1:0]  low address bits of the load
//   rdata   [31:0] word returned by data memory
//   data    [31:0] aligned, extended load value
//   illegal        funct3 is not a legal load encoding
module load_aligner
   import rv32_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data,
   output logic            illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      // Halfword selection looks only at offset[1]; offset[0] is either
      // trapped upstream or deliberately ignored.
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

      data    = rdata;
      illegal = 1'b0;
      case (funct3)
         LB:      data = {{24{byte_sel[7]}}, byte_sel};
         LBU:     data = {24'h0, byte_sel};
         LH:      data = {{16{half_sel[15]}}, half_sel};
         LHU:     data = {16'h0, half_sel};
         LW:      data = rdata;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RV32I writeback stage with data-memory load path
// Optional build macro: LOAD_MISALIGN_TRAP_EN (misaligned LH/LHU/LW fault
// instead of silently ignoring the low address bits).
// Ports:
//   clk, rst (sync, active-low)
//   in_valid/in_ready, in_rd, in_reg_write, in_is_load, in_funct3,
//   in_alu_result                  retiring instruction from execute
//   dmem_req, dmem_addr, dmem_ack, dmem_rdata   data-memory read port
//   rf_write_enable, rf_rd, rf_write_data       register file write port
//   load_fault                     one-cycle fault pulse
module writeback_stage
   import rv32_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   input  logic            in_is_load,
   input  logic [2:0]      in_funct3,
   input  logic [XLEN-1:0] in_alu_result,
   output logic            dmem_req,
   output logic [XLEN-1:0] dmem_addr,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            rf_write_enable,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_write_data,
   output logic            load_fault
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   wb_state_e       state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [4:0]      rd_q, rd_d;
   logic            reg_write_q, reg_write_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [4:0]      rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] wdata_q, wdata_d;

   logic [2:0]      aln_funct3;
   logic [XLEN-1:0] aln_data;
   logic            aln_illegal;
   logic            misalign;

   // One aligner serves both phases: in IDLE it screens the incoming funct3,
   // in MEM_WAIT it formats the returned word for the captured load.
   assign aln_funct3 = (state_q == IDLE) ? in_funct3 : funct3_q;

   load_aligner u_load_aligner (
      .funct3  (aln_funct3),
      .offset  (addr_q[1:0]),
      .rdata   (dmem_rdata),
      .data    (aln_data),
      .illegal (aln_illegal)
   );

`ifdef LOAD_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      if ((in_funct3 == LH || in_funct3 == LHU) && in_alu_result[0])
         misalign = 1'b1;
      if (in_funct3 == LW && in_alu_result[1:0] != 2'b00)
         misalign = 1'b1;
   end
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      rf_rd_d     = rf_rd_q;
      wdata_d     = wdata_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               rd_d        = in_rd;
               reg_write_d = in_reg_write;
               funct3_d    = in_funct3;
               if (!in_is_load) begin
                  rf_rd_d = in_rd;
                  wdata_d = in_alu_result;
                  state_d = WRITE;
               end else if (aln_illegal || misalign) begin
                  state_d = FAULT;
               end else begin
                  addr_d  = in_alu_result;
                  cnt_d   = 8'd0;
                  state_d = MEM_WAIT;
               end
            end
         end
         MEM_WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // Ack is checked first so a reply in the expiring cycle still retires.
            if (dmem_ack) begin
               rf_rd_d = rd_q;
               wdata_d = aln_data;
               state_d = WRITE;
            end else if (cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
               state_d = FAULT;
            end
         end
         WRITE:   state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         rd_q        <= 5'd0;
         reg_write_q <= 1'b0;
         funct3_q    <= 3'd0;
         addr_q      <= '0;
         rf_rd_q     <= 5'd0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         rf_rd_q     <= rf_rd_d;
         wdata_q     <= wdata_d;
      end
   end

   assign in_ready        = (state_q == IDLE);
   assign dmem_req        = (state_q == MEM_WAIT);
   assign dmem_addr       = {addr_q[XLEN-1:2], 2'b00};
   assign rf_write_enable = (state_q == WRITE) && reg_write_q && (rf_rd_q != 5'd0);
   assign rf_rd           = rf_rd_q;
   assign rf_write_data   = wdata_q;
   assign load_fault      = (state_q == FAULT);

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - self-checking bench for writeback_stage
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic [31:0] in_alu_result;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        rf_write_enable;
   logic [4:0]  rf_rd;
   logic [31:0] rf_write_data;
   logic        load_fault;

   always #5 clk = ~clk;

   writeback_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_rd           (in_rd),
      .in_reg_write    (in_reg_write),
      .in_is_load      (in_is_load),
      .in_funct3       (in_funct3),
      .in_alu_result   (in_alu_result),
      .dmem_req        (dmem_req),
      .dmem_addr       (dmem_addr),
      .dmem_ack        (dmem_ack),
      .dmem_rdata      (dmem_rdata),
      .rf_write_enable (rf_write_enable),
      .rf_rd           (rf_rd),
      .rf_write_data   (rf_write_data),
      .load_fault      (load_fault)
   );

   // kind: 0 = no register write, 1 = write, 2 = fault
   typedef struct {
      logic        is_load;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] rdata;
      int          delay;
      int          kind;
      logic [31:0] exp_data;
      int          exp_req;
   } vec_t;

   typedef struct {
      int          kind;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic il, input logic [2:0] f3, input logic [31:0] alu,
                               input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
                               input int delay, input int kind, input logic [31:0] ed,
                               input int er);
      vec_t v;
      v.is_load = il; v.f3 = f3; v.alu = alu; v.rd = rd; v.rw = rw;
      v.rdata = rdata; v.delay = delay; v.kind = kind; v.exp_data = ed; v.exp_req = er;
      return v;
   endfunction

   function automatic logic [31:0] model(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   // Scoreboard consumer: every write strobe or fault pulse pops one entry.
   always @(negedge clk) begin
      exp_t e;
      if (rf_write_enable && load_fault)
         chk("write_and_fault_together", 32'(load_fault), 32'd0);
      if (rf_write_enable) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: rd=%0d data=%h, required no write", rf_rd, rf_write_data);
         end else begin
            e = sb.pop_front();
            chk("wb_kind", 32'(e.kind), 32'd1);
            chk("wb_rd", 32'(rf_rd), 32'(e.rd));
            chk("wb_data", rf_write_data, e.data);
         end
      end
      if (load_fault) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fault: got load_fault=1, required 0");
         end else begin
            e = sb.pop_front();
            chk("fault_kind", 32'(e.kind), 32'd2);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int req_cnt;
      bit done;
      exp_t e;
      if (v.kind != 0) begin
         e.kind = v.kind; e.rd = v.rd; e.data = v.exp_data;
         sb.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b1; in_is_load = v.is_load; in_funct3 = v.f3;
      in_alu_result = v.alu; in_rd = v.rd; in_reg_write = v.rw;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      req_cnt = 0;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (i > 0) @(negedge clk);
         if (dmem_req) begin
            req_cnt++;
            chk("dmem_addr_hold", dmem_addr, {v.alu[31:2], 2'b00});
            if (req_cnt - 1 == v.delay) begin
               dmem_ack = 1'b1; dmem_rdata = v.rdata;
            end else begin
               dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
         end else begin
            dmem_ack = 1'b0;
         end
         if (in_ready) done = 1'b1;
      end
      dmem_ack = 1'b0;
      if (!done) chk("return_to_idle", 32'(in_ready), 32'd1);
      chk("req_cycles", 32'(req_cnt), 32'(v.exp_req));
      chk("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      logic [2:0] f3tab [5];
      logic [2:0] f3;
      logic [1:0] off;
      logic [31:0] addr, word;
      int dly;
      exp_t e;

      f3tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      vecs.push_back(mk(0, 3'b000, 32'hDEADBEEF, 5'd5, 1, 0, -1, 1, 32'hDEADBEEF, 0));
      vecs.push_back(mk(0, 3'b000, 32'h12345678, 5'd0, 1, 0, -1, 0, 0, 0));
      vecs.push_back(mk(0, 3'b000, 32'h00000001, 5'd7, 0, 0, -1, 0, 0, 0));
      vecs.push_back(mk(1, 3'b000, 32'h00001003, 5'd1, 1, 32'h80FF0000, 2, 1, 32'hFFFFFF80, 3));
      vecs.push_back(mk(1, 3'b100, 32'h00001003, 5'd1, 1, 32'h80FF0000, 2, 1, 32'h00000080, 3));
      vecs.push_back(mk(1, 3'b101, 32'h00002002, 5'd2, 1, 32'hABCD1234, 0, 1, 32'h0000ABCD, 1));
      vecs.push_back(mk(1, 3'b001, 32'h00002002, 5'd2, 1, 32'hABCD1234, 1, 1, 32'hFFFFABCD, 2));
      vecs.push_back(mk(1, 3'b010, 32'h00003000, 5'd3, 1, 32'hCAFEF00D, 1, 1, 32'hCAFEF00D, 2));
      vecs.push_back(mk(1, 3'b000, 32'h00004000, 5'd4, 1, 32'h0000007F, 0, 1, 32'h0000007F, 1));
      vecs.push_back(mk(1, 3'b001, 32'h00004000, 5'd6, 1, 32'h00008001, 0, 1, 32'hFFFF8001, 1));
      vecs.push_back(mk(1, 3'b011, 32'h00004000, 5'd6, 1, 0, -1, 2, 0, 0));
      vecs.push_back(mk(1, 3'b110, 32'h00004000, 5'd6, 1, 0, -1, 2, 0, 0));
      vecs.push_back(mk(1, 3'b010, 32'h00005000, 5'd8, 1, 0, -1, 2, 0, 4));
      vecs.push_back(mk(1, 3'b010, 32'h00005004, 5'd8, 1, 32'h5A5AA5A5, 3, 1, 32'h5A5AA5A5, 4));
      vecs.push_back(mk(1, 3'b010, 32'h00005008, 5'd0, 1, 32'h77777777, 0, 0, 0, 1));
`ifdef LOAD_MISALIGN_TRAP_EN
      vecs.push_back(mk(1, 3'b010, 32'h00003001, 5'd9, 1, 32'h11223344, 0, 2, 0, 0));
      vecs.push_back(mk(1, 3'b101, 32'h00003003, 5'd9, 1, 32'h11223344, 0, 2, 0, 0));
`else
      vecs.push_back(mk(1, 3'b010, 32'h00003001, 5'd9, 1, 32'h11223344, 0, 1, 32'h11223344, 1));
      vecs.push_back(mk(1, 3'b101, 32'h00003003, 5'd9, 1, 32'h11223344, 0, 1, 32'h00001122, 1));
`endif
      for (int i = 0; i < 6; i++) begin
         f3 = f3tab[$urandom_range(0, 4)];
         off = 2'($urandom_range(0, 3));
         if (f3 == 3'b001 || f3 == 3'b101) off[0] = 1'b0;
         if (f3 == 3'b010) off = 2'b00;
         addr = {16'h8000, 14'($urandom), off};
         word = $urandom;
         dly = $urandom_range(0, 3);
         vecs.push_back(mk(1, f3, addr, 5'($urandom_range(1, 31)), 1, word, dly, 1,
                           model(f3, off, word), dly + 1));
      end

      rst = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_reg_write = 1'b0; in_is_load = 1'b0;
      in_funct3 = 3'd0; in_alu_result = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(rf_write_enable), 32'd0);
      chk("rst_fault", 32'(load_fault), 32'd0);
      chk("rst_rf_rd", 32'(rf_rd), 32'd0);
      chk("rst_wdata", rf_write_data, 32'd0);
      chk("rst_dmem_addr", dmem_addr, 32'd0);

      // Non-load latency: strobe in N+1 only, ready again in N+2.
      e.kind = 1; e.rd = 5'd9; e.data = 32'h0BADF00D;
      sb.push_back(e);
      in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd9; in_reg_write = 1'b1;
      in_alu_result = 32'h0BADF00D; in_funct3 = 3'd0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("lat_we_n1", 32'(rf_write_enable), 32'd1);
      chk("lat_ready_n1", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("lat_we_n2", 32'(rf_write_enable), 32'd0);
      chk("lat_ready_n2", 32'(in_ready), 32'd1);
      chk("hold_wdata", rf_write_data, 32'h0BADF00D);
      chk("hold_rf_rd", 32'(rf_rd), 32'd9);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset in the middle of a pending load, followed by a late ack.
      @(negedge clk);
      in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_rd = 5'd12;
      in_reg_write = 1'b1; in_alu_result = 32'h00006000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk("mid_req_up", 32'(dmem_req), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_req", 32'(dmem_req), 32'd0);
      chk("mid_rst_idle", 32'(in_ready), 32'd1);
      chk("mid_rst_we", 32'(rf_write_enable), 32'd0);
      chk("mid_rst_addr", dmem_addr, 32'd0);
      chk("mid_rst_wdata", rf_write_data, 32'd0);
      chk("mid_rst_rf_rd", 32'(rf_rd), 32'd0);
      rst = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'hFEEDFACE;
      @(negedge clk);
      dmem_ack = 1'b0;
      chk("late_ack_req", 32'(dmem_req), 32'd0);
      chk("late_ack_we", 32'(rf_write_enable), 32'd0);
      @(negedge clk);
      chk("late_ack_we2", 32'(rf_write_enable), 32'd0);
      chk("late_ack_idle", 32'(in_ready), 32'd1);
      chk("late_ack_wdata", rf_write_data, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the RV32I core: accepts a retiring instruction from execute, performs the data-memory read for loads, aligns and sign/zero-extends load data, and drives the register file write port (`rf_write_enable`, `rf_rd`, `rf_write_data`). Non-load results pass through in one cycle. Loads hold a valid/ack request to data memory, guarded by a timeout counter. Faulting accesses retire with no register write.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles in MEM_WAIT before a load faults; range 1..255.

Ports:
- `clk`  in  1  core clock; all logic on rising edge
- `rst`  in  1  synchronous, active-low reset
- `in_valid`  in  1  execute presents a retiring instruction
- `in_ready`  out  1  stage can accept; high only in IDLE
- `in_rd`  in  5  destination register
- `in_reg_write`  in  1  instruction writes rd
- `in_is_load`  in  1  instruction is a load
- `in_funct3`  in  3  load width/sign (LB=000, LH=001, LW=010, LBU=100, LHU=101)
- `in_alu_result`  in  32  load address if load, else writeback value
- `dmem_req`  out  1  read request, held until ack
- `dmem_addr`  out  32  word-aligned address (`{addr[31:2],2'b00}`)
- `dmem_ack`  in  1  read data valid this cycle
- `dmem_rdata`  in  32  read word
- `rf_write_enable`  out  1  one-cycle register write strobe
- `rf_rd`  out  5  write address
- `rf_write_data`  out  32  write data
- `load_fault`  out  1  one-cycle pulse: timeout, bad funct3, or misalignment (see Configuration)

## Operation
- FSM states: IDLE, MEM_WAIT, WRITE, FAULT.
- IDLE: `in_ready`=1. On `in_valid`, capture rd, reg_write, funct3, alu_result.
  - Non-load: go to WRITE.
  - Load with valid funct3 and an accepted alignment: assert `dmem_req` from the next cycle and go to MEM_WAIT. Clear the timeout counter.
  - Load with an illegal funct3 (011, 110, 111), or a rejected alignment: go to FAULT and issue no request.
- MEM_WAIT: `dmem_req`=1. `dmem_addr` stays stable. The counter increments each cycle.
  - On `dmem_ack`: capture the aligned data and go to WRITE.
  - If the counter reaches TIMEOUT_CYCLES with no ack: go to FAULT.
  - If ack arrives in the same cycle the counter expires, ack wins.
- WRITE: one cycle only, then IDLE.
  - `rf_write_enable` = `reg_write && rd != 0`.
  - `rf_rd` = captured rd.
  - `rf_write_data` = pass-through value or aligned load data.
- FAULT: `load_fault`=1 for one cycle, no register write, then IDLE.
- Alignment, using offset `a = addr[1:0]`:
  - LB/LBU: byte `rdata[8a+7:8a]`, sign- or zero-extended.
  - LH/LHU: half `rdata[16*a[1]+15:16*a[1]]`, sign- or zero-extended.
  - LW: the full word.
- `rf_write_data` and `rf_rd` hold their last values outside WRITE. Only `rf_write_enable` qualifies them.

## Timing
- Reset (`rst`=0 at a clock edge) has priority in every state, including mid-request:
  - state goes to IDLE and the counter to 0;
  - `dmem_req`, `rf_write_enable` and `load_fault` go to 0;
  - `rf_rd` goes to 0, and `rf_write_data` and `dmem_addr` to 32'h0;
  - `in_ready` goes to 1 on the first cycle after reset deasserts.
- Non-load latency: accept at edge N, `rf_write_enable` high during cycle N+1, `in_ready` high again in cycle N+2.
- Load latency: `dmem_req` high from cycle N+1; ack sampled at edge M; write strobe in cycle M+1.
- Minimum load: ack in the first MEM_WAIT cycle gives a write strobe 2 cycles after accept.
- `dmem_ack` is ignored outside MEM_WAIT.
- `in_valid` is ignored while `in_ready`=0. Upstream holds its data until accepted.

## Configuration
- `LOAD_MISALIGN_TRAP_EN` defined: misaligned loads are rejected into FAULT with no memory request. A load is misaligned when:
  - LH/LHU has `addr[0]`=1, or
  - LW has `addr[1:0]` != 0.
- Undefined: misaligned low address bits are silently ignored. LH/LHU use only `addr[1]`; LW ignores `addr[1:0]`. No fault is raised for alignment.
- Timeout and illegal-funct3 faults exist in both builds.

## Structure
- Shared package `rv32_pkg`:
  - `load_funct3_e` (LB, LH, LW, LBU, LHU encodings);
  - `wb_state_e` (IDLE, MEM_WAIT, WRITE, FAULT);
  - constant `XLEN=32`.
- Sub-module `load_aligner`, purely combinational:
  - inputs `funct3`, `offset[1:0]`, `rdata[31:0]`;
  - outputs `data[31:0]` and an `illegal` flag.

## Test plan
- ALU result 32'hDEADBEEF, rd=5, reg_write=1: `rf_write_enable` pulses exactly in cycle N+1 with rd=5 and data DEADBEEF. Repeating with rd=0 gives no write strobe.
- LB at addr 0x1003, rdata 32'h80FF_0000, ack after 3 cycles: `dmem_addr`=0x1000 is held, then write data = 32'hFFFFFF80. LBU at the same address writes 32'h00000080.
- LHU at addr 0x2002, rdata 32'hABCD_1234: writes 32'h0000ABCD. LH at the same address writes 32'hFFFFABCD.
- Load with no ack and TIMEOUT_CYCLES=4: after 4 MEM_WAIT cycles, `dmem_req` drops, `load_fault` pulses once, there is no write, and `in_ready` returns. Ack coinciding with expiry gives a normal write and no fault.
- LW at addr 0x3001: with `LOAD_MISALIGN_TRAP_EN`, `load_fault` pulses and `dmem_req` never rises. Without it, `dmem_addr`=0x3000 and the full word is written.
- `rst`=0 asserted mid-MEM_WAIT: the next cycle shows `dmem_req`=0, state IDLE and no write. A late ack after reset is ignored.
